// File: rtl/crossbar_pkg.sv
// Shared types for the single-input crossbar: output buffer state encoding
// and a destination range check.
package crossbar_pkg;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

   function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
      return (sel < n);
   endfunction

endpackage

// File: rtl/crossbar_out_buffer.sv
// One-entry message/destination buffer with val/rdy on both sides; accepts a
// new entry in the same cycle the held one drains.
module crossbar_out_buffer
   import crossbar_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int DST_W     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_val,
   output logic                 in_rdy,
   input  logic [BIT_WIDTH-1:0] in_msg,
   input  logic [DST_W-1:0]     in_dst,
   output logic                 out_val,
   input  logic                 out_rdy,
   output logic [BIT_WIDTH-1:0] out_msg,
   output logic [DST_W-1:0]     out_dst
);

   buf_state_e             state_r;
   buf_state_e             state_next_s;
   logic                   fire_s;
   logic [BIT_WIDTH-1:0]   msg_r;
   logic [DST_W-1:0]       dst_r;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: a load always leaves us FULL, a drain without a load empties
   always_comb begin
      state_next_s = state_r;
      fire_s       = (state_r == FULL) && out_rdy;
      case (state_r)
         EMPTY: begin
            if (in_val) begin
               state_next_s = FULL;
            end else begin
               state_next_s = EMPTY;
            end
         end
         FULL: begin
            if (fire_s && !in_val) begin
               state_next_s = EMPTY;
            end else begin
               state_next_s = FULL;
            end
         end
         default: state_next_s = EMPTY;
      endcase
   end

   // Payload register
   always_ff @(posedge clk) begin
      if (reset) begin
         msg_r <= {BIT_WIDTH{1'b0}};
         dst_r <= {DST_W{1'b0}};
      end else if (in_val) begin
         msg_r <= in_msg;
         dst_r <= in_dst;
      end
   end

   assign in_rdy  = (state_r == EMPTY) || fire_s;
   assign out_val = (state_r == FULL);
   assign out_msg = msg_r;
   assign out_dst = dst_r;

endmodule

// File: rtl/crossbar_one_in.sv
// One-input, N-output crossbar routed by a registered control word.
// Define CROSSBAR_ONE_IN_COUNT_EN to add the 32-bit send_count output.
module crossbar_one_in
   import crossbar_pkg::*;
#(
   parameter int BIT_WIDTH         = 32,
   parameter int N_OUTPUTS         = 2,
   parameter int CONTROL_BIT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [BIT_WIDTH-1:0]         recv_msg,
   input  logic                         recv_val,
   output logic                         recv_rdy,
   output logic [BIT_WIDTH-1:0]         send_msg [0:N_OUTPUTS-1],
   output logic                         send_val [0:N_OUTPUTS-1],
   input  logic                         send_rdy [0:N_OUTPUTS-1],
   input  logic [CONTROL_BIT_WIDTH-1:0] control,
   input  logic                         control_val,
   output logic                         control_rdy
`ifdef CROSSBAR_ONE_IN_COUNT_EN
   ,
   output logic [31:0]                  send_count
`endif
);

   localparam int SEL_W = $clog2(N_OUTPUTS);

   logic [CONTROL_BIT_WIDTH-1:0] stored_control_r;
   logic [SEL_W-1:0]             sel_s;
   logic                         sel_valid_s;
   logic                         accept_s;
   logic                         load_s;
   logic                         buf_in_rdy_s;
   logic                         buf_full_s;
   logic                         out_rdy_s;
   logic                         send_fire_s;
   logic [BIT_WIDTH-1:0]         buf_msg_s;
   logic [SEL_W-1:0]             buf_dst_s;

   // Control word register; always ready to take a new destination
   always_ff @(posedge clk) begin
      if (reset) begin
         stored_control_r <= {CONTROL_BIT_WIDTH{1'b0}};
      end else if (control_val) begin
         stored_control_r <= control;
      end
   end

   assign control_rdy = 1'b1;
   assign sel_s       = stored_control_r[CONTROL_BIT_WIDTH-1 -: SEL_W];
   assign sel_valid_s = sel_in_range(32'(sel_s), N_OUTPUTS);

   // A control transfer takes priority: the inbound message waits a cycle
   // so it is routed by the freshly stored destination.
   assign recv_rdy = !reset && !control_val && buf_in_rdy_s;
   assign accept_s = recv_val && recv_rdy;
   assign load_s   = accept_s && sel_valid_s;

   // Ready of the port the buffered message is headed for
   always_comb begin
      out_rdy_s = 1'b0;
      for (int j = 0; j < N_OUTPUTS; j++) begin
         out_rdy_s = out_rdy_s | (send_rdy[j] & (buf_dst_s == SEL_W'(j)));
      end
   end

   assign send_fire_s = buf_full_s && out_rdy_s;

   crossbar_out_buffer #(
      .BIT_WIDTH (BIT_WIDTH),
      .DST_W     (SEL_W)
   ) u_out_buffer (
      .clk     (clk),
      .reset   (reset),
      .in_val  (load_s),
      .in_rdy  (buf_in_rdy_s),
      .in_msg  (recv_msg),
      .in_dst  (sel_s),
      .out_val (buf_full_s),
      .out_rdy (out_rdy_s),
      .out_msg (buf_msg_s),
      .out_dst (buf_dst_s)
   );

   for (genvar j = 0; j < N_OUTPUTS; j++) begin : g_port
      assign send_val[j] = !reset && buf_full_s && (buf_dst_s == SEL_W'(j));
      assign send_msg[j] = buf_msg_s;
   end

`ifdef CROSSBAR_ONE_IN_COUNT_EN
   // Delivered-message counter, wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         send_count <= 32'd0;
      end else if (send_fire_s) begin
         send_count <= send_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_crossbar_one_in.sv
// Directed table-driven bench for crossbar_one_in (N_OUTPUTS=2 instance) plus
// hand sequences for reset-while-full and out-of-range select (N_OUTPUTS=3).
module tb_crossbar_one_in;

   logic clk;
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- N_OUTPUTS = 2 instance ----
   logic        reset2;
   logic [31:0] recv_msg2;
   logic        recv_val2;
   logic        recv_rdy2;
   logic [31:0] send_msg2 [0:1];
   logic        send_val2 [0:1];
   logic        send_rdy2 [0:1];
   logic [31:0] control2;
   logic        control_val2;
   logic        control_rdy2;
`ifdef CROSSBAR_ONE_IN_COUNT_EN
   logic [31:0] send_count2;
`endif

   crossbar_one_in #(.BIT_WIDTH(32), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(32)) dut2 (
      .clk         (clk),
      .reset       (reset2),
      .recv_msg    (recv_msg2),
      .recv_val    (recv_val2),
      .recv_rdy    (recv_rdy2),
      .send_msg    (send_msg2),
      .send_val    (send_val2),
      .send_rdy    (send_rdy2),
      .control     (control2),
      .control_val (control_val2),
      .control_rdy (control_rdy2)
`ifdef CROSSBAR_ONE_IN_COUNT_EN
      ,
      .send_count  (send_count2)
`endif
   );

   // ---- N_OUTPUTS = 3 instance ----
   logic        reset3;
   logic [31:0] recv_msg3;
   logic        recv_val3;
   logic        recv_rdy3;
   logic [31:0] send_msg3 [0:2];
   logic        send_val3 [0:2];
   logic        send_rdy3 [0:2];
   logic [31:0] control3;
   logic        control_val3;
   logic        control_rdy3;
`ifdef CROSSBAR_ONE_IN_COUNT_EN
   logic [31:0] send_count3;
`endif

   crossbar_one_in #(.BIT_WIDTH(32), .N_OUTPUTS(3), .CONTROL_BIT_WIDTH(32)) dut3 (
      .clk         (clk),
      .reset       (reset3),
      .recv_msg    (recv_msg3),
      .recv_val    (recv_val3),
      .recv_rdy    (recv_rdy3),
      .send_msg    (send_msg3),
      .send_val    (send_val3),
      .send_rdy    (send_rdy3),
      .control     (control3),
      .control_val (control_val3),
      .control_rdy (control_rdy3)
`ifdef CROSSBAR_ONE_IN_COUNT_EN
      ,
      .send_count  (send_count3)
`endif
   );

   typedef struct packed {
      logic        rv;
      logic [31:0] msg;
      logic        cv;
      logic [31:0] ctl;
      logic [1:0]  srdy;
      logic        e_rrdy;
      logic [1:0]  e_sval;
      logic [31:0] e_msg;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rv, input logic [31:0] msg, input logic cv,
                      input logic [31:0] ctl, input logic [1:0] srdy,
                      input logic e_rrdy, input logic [1:0] e_sval, input logic [31:0] e_msg);
      vec_t v;
      v.rv = rv; v.msg = msg; v.cv = cv; v.ctl = ctl; v.srdy = srdy;
      v.e_rrdy = e_rrdy; v.e_sval = e_sval; v.e_msg = e_msg;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] sval2();
      return {send_val2[1], send_val2[0]};
   endfunction

   function automatic logic [2:0] sval3();
      return {send_val3[2], send_val3[1], send_val3[0]};
   endfunction

   initial begin
      // Stimulus table: inputs for the cycle and outputs expected in that same cycle
      add(1'b0, 32'h0,      1'b1, 32'h8000_0000, 2'b10, 1'b0, 2'b00, 32'h0);      // r0  ctl -> dst1
      add(1'b1, 32'hAAAA,   1'b0, 32'h0,         2'b10, 1'b1, 2'b00, 32'h0);      // r1  accept AAAA
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b10, 1'b1, 2'b10, 32'hAAAA);   // r2  out port1
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b00, 1'b1, 2'b00, 32'h0);      // r3  empty
      add(1'b0, 32'h0,      1'b1, 32'h0,         2'b00, 1'b0, 2'b00, 32'h0);      // r4  ctl -> dst0
      add(1'b1, 32'h1,      1'b0, 32'h0,         2'b00, 1'b1, 2'b00, 32'h0);      // r5  accept 1
      add(1'b1, 32'h2,      1'b0, 32'h0,         2'b00, 1'b0, 2'b01, 32'h1);      // r6  2 stalled
      add(1'b1, 32'h2,      1'b0, 32'h0,         2'b00, 1'b0, 2'b01, 32'h1);      // r7  held stable
      add(1'b1, 32'h2,      1'b0, 32'h0,         2'b01, 1'b1, 2'b01, 32'h1);      // r8  1 out, 2 in
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b01, 1'b1, 2'b01, 32'h2);      // r9  2 out
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0);      // r10 empty
      add(1'b1, 32'h5,      1'b0, 32'h0,         2'b00, 1'b1, 2'b00, 32'h0);      // r11 accept 5 dst0
      add(1'b0, 32'h0,      1'b1, 32'h8000_0000, 2'b00, 1'b0, 2'b01, 32'h5);      // r12 ctl -> dst1
      add(1'b1, 32'h6,      1'b0, 32'h0,         2'b01, 1'b1, 2'b01, 32'h5);      // r13 5 still port0
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b10, 1'b1, 2'b10, 32'h6);      // r14 6 on port1
      add(1'b1, 32'h7,      1'b1, 32'h0,         2'b11, 1'b0, 2'b00, 32'h0);      // r15 ctl blocks recv
      add(1'b1, 32'h7,      1'b0, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0);      // r16 accept 7
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b11, 1'b1, 2'b01, 32'h7);      // r17 7 on port0
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0);      // r18 empty
      add(1'b0, 32'h0,      1'b1, 32'h7FFF_FFFF, 2'b01, 1'b0, 2'b00, 32'h0);      // r19 only msb selects
      add(1'b1, 32'h9,      1'b0, 32'h0,         2'b01, 1'b1, 2'b00, 32'h0);      // r20 accept 9
      add(1'b0, 32'h0,      1'b0, 32'h0,         2'b01, 1'b1, 2'b01, 32'h9);      // r21 9 on port0

      reset2 = 1'b1; recv_val2 = 1'b1; recv_msg2 = 32'h1234; control_val2 = 1'b0; control2 = 32'h0;
      send_rdy2[0] = 1'b1; send_rdy2[1] = 1'b1;
      reset3 = 1'b1; recv_val3 = 1'b0; recv_msg3 = 32'h0; control_val3 = 1'b0; control3 = 32'h0;
      send_rdy3[0] = 1'b0; send_rdy3[1] = 1'b0; send_rdy3[2] = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_recv_rdy", 32'(recv_rdy2), 32'h0);
      chk("reset_send_val", 32'(sval2()), 32'h0);
      chk("control_rdy", 32'(control_rdy2), 32'h1);
      @(negedge clk);
      reset2 = 1'b0; recv_val2 = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         recv_val2    = vq[i].rv;
         recv_msg2    = vq[i].msg;
         control_val2 = vq[i].cv;
         control2     = vq[i].ctl;
         send_rdy2[0] = vq[i].srdy[0];
         send_rdy2[1] = vq[i].srdy[1];
         #1;
         chk($sformatf("row%0d_recv_rdy", i), 32'(recv_rdy2), 32'(vq[i].e_rrdy));
         chk($sformatf("row%0d_send_val", i), 32'(sval2()), 32'(vq[i].e_sval));
         if (vq[i].e_sval != 2'b00) begin
            chk($sformatf("row%0d_send_msg0", i), send_msg2[0], vq[i].e_msg);
            chk($sformatf("row%0d_send_msg1", i), send_msg2[1], vq[i].e_msg);
         end
      end

      // Reset while FULL: buffered message is dropped
      @(negedge clk);
      recv_val2 = 1'b1; recv_msg2 = 32'hDEAD; control_val2 = 1'b0;
      send_rdy2[0] = 1'b0; send_rdy2[1] = 1'b0;
      #1;
`ifdef CROSSBAR_ONE_IN_COUNT_EN
      chk("send_count_after_table", send_count2, 32'd7);
`endif
      chk("full_accept_rdy", 32'(recv_rdy2), 32'h1);
      @(negedge clk);
      recv_val2 = 1'b0;
      #1;
      chk("full_before_reset", 32'(sval2()), 32'h1);
      @(negedge clk);
      reset2 = 1'b1;
      #1;
      chk("in_reset_send_val", 32'(sval2()), 32'h0);
      chk("in_reset_recv_rdy", 32'(recv_rdy2), 32'h0);
      @(negedge clk);
      reset2 = 1'b0;
      #1;
      chk("after_reset_send_val", 32'(sval2()), 32'h0);
      chk("after_reset_empty", 32'(recv_rdy2), 32'h1);
`ifdef CROSSBAR_ONE_IN_COUNT_EN
      chk("after_reset_count", send_count2, 32'd0);
`endif

      // N_OUTPUTS=3: sel=3 is out of range and must be discarded
      @(negedge clk);
      reset3 = 1'b0;
      @(negedge clk);
      control_val3 = 1'b1; control3 = 32'hC000_0000;
      #1;
      chk("n3_ctl_blocks", 32'(recv_rdy3), 32'h0);
      @(negedge clk);
      control_val3 = 1'b0; recv_val3 = 1'b1; recv_msg3 = 32'h33;
      #1;
      chk("n3_discard_accept", 32'(recv_rdy3), 32'h1);
      @(negedge clk);
      recv_val3 = 1'b0;
      #1;
      chk("n3_discard_no_val", 32'(sval3()), 32'h0);
      chk("n3_discard_empty", 32'(recv_rdy3), 32'h1);
      @(negedge clk);
      control_val3 = 1'b1; control3 = 32'h8000_0000;
      @(negedge clk);
      control_val3 = 1'b0; recv_val3 = 1'b1; recv_msg3 = 32'h44;
      @(negedge clk);
      recv_val3 = 1'b0;
      #1;
      chk("n3_port2_val", 32'(sval3()), 32'h4);
      chk("n3_port2_msg", send_msg3[2], 32'h44);
      chk("n3_port2_stall", 32'(recv_rdy3), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crossbar_one_in.md
CROSSBAR_ONE_IN -- requirements
Module: crossbar_one_in

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, message width in bits.
REQ-002 SHALL have parameter N_OUTPUTS, default 2, number of output ports (>=2).
REQ-003 SHALL have parameter CONTROL_BIT_WIDTH, default 32, control word width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port recv_msg, input, BIT_WIDTH bits, inbound message.
REQ-007 SHALL have ports recv_val (input, 1 bit) and recv_rdy (output, 1 bit), the inbound handshake.
REQ-008 SHALL have port send_msg, output, unpacked array [0:N_OUTPUTS-1] of BIT_WIDTH bits, outbound messages.
REQ-009 SHALL have ports send_val (output) and send_rdy (input), each unpacked [0:N_OUTPUTS-1] of 1 bit.
REQ-010 SHALL have port control, input, CONTROL_BIT_WIDTH bits, destination select word.
REQ-011 SHALL have ports control_val (input, 1 bit) and control_rdy (output, 1 bit), the control handshake.

Function
REQ-012 SHALL take the destination index sel from control[CONTROL_BIT_WIDTH-1 -: $clog2(N_OUTPUTS)].
REQ-013 SHALL hold stored_control in a register, loaded when control_val && control_rdy; control_rdy SHALL be constant 1.
REQ-014 SHALL use a one-entry output buffer with FSM states EMPTY and FULL, holding buf_msg and buf_dst.
REQ-015 SHALL define send_fire as: FULL && send_rdy[buf_dst].
REQ-016 SHALL drive recv_rdy = !(control_val) && (EMPTY || send_fire); a control transfer blocks the inbound message that cycle.
REQ-017 SHALL, on recv_val && recv_rdy with stored sel < N_OUTPUTS, load buf_msg <= recv_msg and buf_dst <= sel, and enter/stay FULL.
REQ-018 SHALL, on recv_val && recv_rdy with stored sel >= N_OUTPUTS, accept and discard the message, with no send_val asserted.
REQ-019 SHALL, on send_fire without a new accept, go FULL -> EMPTY; on send_fire with an accept, stay FULL (back-to-back, one message/cycle).
REQ-020 SHALL drive send_val[j] = FULL && (j == buf_dst), and drive send_msg[j] = buf_msg for all j.
REQ-021 SHALL give one-cycle latency: a message accepted in cycle t SHALL be presented at the output in cycle t+1.
REQ-022 SHALL NOT let a control update alter buf_dst of an already-buffered message; the new sel applies only to messages accepted after the update.
REQ-023 SHALL hold send_val and buf contents stable while FULL and send_rdy[buf_dst]=0.

Reset
REQ-024 SHALL, while reset=1, force state EMPTY, stored_control=0, buf_msg=0, buf_dst=0.
REQ-025 SHALL, during reset, drive all send_val=0 and recv_rdy=0; a message buffered at reset assertion SHALL be lost.

Configuration
REQ-026 SHALL, with macro CROSSBAR_ONE_IN_COUNT_EN defined, add output send_count (32 bits), which increments on each send_fire, wraps 2^32-1 -> 0, and resets to 0.
REQ-027 SHALL, without CROSSBAR_ONE_IN_COUNT_EN, have no send_count port and no counter logic.

Structure
REQ-028 SHALL place the FSM state enum (EMPTY, FULL) in a shared package, crossbar_pkg.
REQ-029 SHALL implement the buffer as one sub-module, crossbar_out_buffer (msg+dst register with val/rdy), instantiated once.

Verification
REQ-030 SHALL cover: reset, then control=0x8000_0000 (N_OUTPUTS=2), send 0xAAAA with send_rdy[1]=1 -> send_val[1]=1 and send_msg[1]=0xAAAA the next cycle, send_val[0]=0.
REQ-031 SHALL cover: send_rdy all 0 and two messages 0x1, 0x2 offered -> 0x1 held, recv_rdy=0 for 0x2; raising send_rdy delivers 0x1 then 0x2 in consecutive cycles.
REQ-032 SHALL cover: 0x5 buffered for dst 0, then control switched to dst 1 -> 0x5 still exits port 0, and the next message exits port 1.
REQ-033 SHALL cover: control_val and recv_val in the same cycle -> recv_rdy=0 and the message is routed by the new control one cycle later.
REQ-034 SHALL cover: N_OUTPUTS=3 with sel=3 -> message accepted, no send_val on any port, state stays EMPTY.
REQ-035 SHALL cover: reset asserted while FULL -> next cycle all send_val=0 and send_count=0 when CROSSBAR_ONE_IN_COUNT_EN is defined.
